// File: rtl/ocimem_debug_ram_pkg.sv
// Shared types and constants for the OCI debug RAM stage.
// Holds the FSM state encoding, JTAG op codes, jdo field positions and control bit indices.
// No logic; imported by the top module and the bench.
package ocimem_debug_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_ARD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        JOP_LOAD  = 2'd0,
        JOP_WRITE = 2'd1,
        JOP_READ  = 2'd2
    } jop_t;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_CLR_BIT   = 35;

    localparam int CTRL_READY = 0;
    localparam int CTRL_ERROR = 1;

    // Control register read-back word.
    function automatic logic [31:0] ctrl_word(input logic err, input logic rdy);
        return {30'b0, err, rdy};
    endfunction

endpackage

// File: rtl/ocimem_debug_ram_if.sv
// Avalon-MM slave bus into the debug RAM (MSB of address selects the control register).
// Read data and waitrequest come back from the slave; waitrequest is combinational.
// Master holds address/command/data stable while waitrequest is high.
interface ocimem_debug_ram_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W:0] avs_address;
    logic            avs_read;
    logic            avs_write;
    logic [31:0]     avs_writedata;
    logic [3:0]      avs_byteenable;
    logic [31:0]     avs_readdata;
    logic            avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/ocimem_debug_ram_ram_sp.sv
// Byte-enabled 2^ADDR_W x 32 synchronous single-port RAM.
// Latency: 1 cycle read (data registered every cycle from i_addr); write lands at the clock edge.
// No backpressure; no reset on storage or read port.
module ocimem_ram_sp #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/ocimem_debug_ram.sv
// Debug RAM shared by the JTAG debug path and the CPU Avalon master, plus monitor flags.
// Latency: JTAG read 2 cycles to MonDReg, JTAG write 1 cycle; Avalon RAM read 1 wait state.
// JTAG beats Avalon at IDLE; Avalon is stalled by combinational waitrequest, JTAG uses a 1-deep slot.
module ocimem_debug_ram
    import ocimem_debug_ram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    ocimem_debug_ram_if.slave avs,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_jaddr;

    // Pending slot keeps only the jdo bits that any op uses.
    logic                              r_pend_vld;
    jop_t                              r_pend_op;
    logic [JDO_CLR_BIT:JDO_WDATA_LSB]  r_pend_jdo;

    logic                              w_strb_vld;
    jop_t                              w_strb_op;
    logic                              w_jreq_vld;
    jop_t                              w_jreq_op;
    logic [JDO_CLR_BIT:JDO_WDATA_LSB]  w_jreq_jdo;
    logic                              w_jserve;
    logic                              w_unused_ok;

    logic              w_avs_ctrl, w_avs_ctrl_rd, w_avs_req, w_avs_done;
    logic [1:0]        w_ctrl_set;
    logic              w_flag_clr;
    logic [31:0]       r_rdata;

    logic              w_ram_we;
    logic [3:0]        w_ram_be;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_wdata, w_ram_q;

    assign w_unused_ok = ^{jdo[37:36], jdo[2:0]};

    // Strobe decode with fixed priority: load/control > write > read.
    always_comb begin
        w_strb_vld = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        w_strb_op  = JOP_READ;
        if (take_action_ocimem_a)      w_strb_op = JOP_LOAD;
        else if (take_action_ocimem_b) w_strb_op = JOP_WRITE;
    end

    // A live strobe is the newest request, so it supersedes whatever sits in the slot.
    assign w_jreq_vld = w_strb_vld | r_pend_vld;
    assign w_jreq_op  = w_strb_vld ? w_strb_op : r_pend_op;
    assign w_jreq_jdo = w_strb_vld ? jdo[JDO_CLR_BIT:JDO_WDATA_LSB] : r_pend_jdo;
    assign w_jserve   = (r_state == ST_IDLE) && w_jreq_vld;

    assign w_avs_ctrl    = avs.avs_address[ADDR_W];
    assign w_avs_req     = avs.avs_read | avs.avs_write;
    assign w_avs_ctrl_rd = (r_state == ST_IDLE) && avs.avs_read && !avs.avs_write && w_avs_ctrl;
    assign w_flag_clr    = w_jserve && (w_jreq_op == JOP_LOAD) && w_jreq_jdo[JDO_CLR_BIT];

    // Next-state, RAM port steering and Avalon completion.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'h0;
        w_ram_addr  = r_jaddr;
        w_ram_wdata = w_jreq_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        w_avs_done  = 1'b0;
        w_ctrl_set  = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_avs_ctrl_rd) w_avs_done = 1'b1;
                if (w_jreq_vld) begin
                    if (w_jreq_op == JOP_READ) begin
                        w_state_nxt = ST_JRD;
                    end else if (w_jreq_op == JOP_WRITE) begin
                        w_ram_we = 1'b1;
                        w_ram_be = 4'hF;
                    end
                end else if (avs.avs_write) begin
                    w_avs_done = 1'b1;
                    if (w_avs_ctrl) begin
                        w_ctrl_set = avs.avs_writedata[CTRL_ERROR:CTRL_READY];
                    end else begin
                        w_ram_we    = 1'b1;
                        w_ram_be    = avs.avs_byteenable;
                        w_ram_addr  = avs.avs_address[ADDR_W-1:0];
                        w_ram_wdata = avs.avs_writedata;
                    end
                end else if (avs.avs_read && !w_avs_ctrl) begin
                    w_ram_addr  = avs.avs_address[ADDR_W-1:0];
                    w_state_nxt = ST_ARD;
                end
            end
            ST_JRD:  w_state_nxt = ST_IDLE;
            ST_ARD: begin
                w_state_nxt = ST_IDLE;
                w_avs_done  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (reset) w_ram_we = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // JTAG address pointer, MonDReg capture and pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jaddr    <= '0;
            MonDReg    <= '0;
            r_pend_vld <= 1'b0;
            r_pend_op  <= JOP_LOAD;
            r_pend_jdo <= '0;
        end else begin
            if (w_jserve) begin
                r_pend_vld <= 1'b0;
                if (w_jreq_op == JOP_LOAD)       r_jaddr <= w_jreq_jdo[JDO_ADDR_LSB +: ADDR_W];
                else if (w_jreq_op == JOP_WRITE) r_jaddr <= r_jaddr + ADDR_W'(1);
            end else if (w_strb_vld) begin
                r_pend_vld <= 1'b1;
                r_pend_op  <= w_strb_op;
                r_pend_jdo <= jdo[JDO_CLR_BIT:JDO_WDATA_LSB];
            end
            if (r_state == ST_JRD) begin
                MonDReg <= w_ram_q;
                r_jaddr <= r_jaddr + ADDR_W'(1);
            end
        end
    end

    // Monitor flags: an Avalon set in the same cycle as a JTAG clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            monitor_ready <= (monitor_ready & ~w_flag_clr) | w_ctrl_set[CTRL_READY];
            monitor_error <= (monitor_error & ~w_flag_clr) | w_ctrl_set[CTRL_ERROR];
        end
    end

    // Hold the last Avalon read result so readdata stays stable after completion.
    always_ff @(posedge clk) begin
        if (reset)                  r_rdata <= '0;
        else if (r_state == ST_ARD) r_rdata <= w_ram_q;
        else if (w_avs_ctrl_rd)     r_rdata <= ctrl_word(monitor_error, monitor_ready);
    end

    assign avs.avs_readdata    = (r_state == ST_ARD) ? w_ram_q :
                                 w_avs_ctrl_rd       ? ctrl_word(monitor_error, monitor_ready) :
                                                       r_rdata;
    assign avs.avs_waitrequest = reset | (w_avs_req & ~w_avs_done);

    ocimem_ram_sp #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );
endmodule
